// File: rtl/sig_cond_pkg.sv
// Shared constants and types for the sig_in pin conditioning path.
package sig_cond_pkg;

    localparam int DEBOUNCE_10MS_100MHZ = 1000000;
    localparam int SIM_DEBOUNCE_CYCLES  = 4;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } deb_state_t;

endpackage

// File: rtl/sig_debounce_bit.sv
// One input bit: synchroniser chain, debounce FSM with persistence counter,
// and registered rise/fall strobes.
module sig_debounce_bit
    import sig_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter logic RST_BIT         = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    deb_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_q;
    logic                   w_diff;
    logic                   w_accept;

    // Synchroniser: plain flop chain, nothing between stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RST_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_sync_q ^ r_stable;
    assign w_accept = (r_state == COUNT) && w_diff && (r_cnt == CNT_MAX);

    // Debounce: any return to the accepted level restarts the count from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= STABLE;
            r_cnt    <= '0;
            r_stable <= RST_BIT;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE: begin
                    if (w_diff) begin
                        r_state <= COUNT;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                COUNT: begin
                    if (!w_diff) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_stable <= w_sync_q;
                        r_rise   <= w_sync_q;
                        r_fall   <= ~w_sync_q;
                        r_state  <= STABLE;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule

// File: rtl/sig_in_conditioner.sv
// Conditions the raw sig_in pins: per-bit sync + debounce, with clean levels,
// edge strobes and a combined change flag for the downstream user logic.
module sig_in_conditioner
    import sig_cond_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter logic [WIDTH-1:0] RST_VAL         = {WIDTH{1'b0}}
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig_raw,
    output logic [WIDTH-1:0] sig_stable,
    output logic [WIDTH-1:0] sig_rise,
    output logic [WIDTH-1:0] sig_fall,
    output logic             chg_any
);

    logic [WIDTH-1:0] w_accept;
    logic             r_chg_any;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sig_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_BIT         (RST_VAL[gi])
        ) u_bit (
            .i_clk    (sys_clock),
            .i_rst_n  (reset),
            .i_raw    (sig_raw[gi]),
            .o_stable (sig_stable[gi]),
            .o_rise   (sig_rise[gi]),
            .o_fall   (sig_fall[gi]),
            .o_accept (w_accept[gi])
        );
    end

    // Registered from the accept terms so it lands in the same cycle as the strobes.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            r_chg_any <= 1'b0;
        end else begin
            r_chg_any <= |w_accept;
        end
    end

    assign chg_any = r_chg_any;

endmodule

// File: tb/tb_sig_in_conditioner.sv
// Scoreboard bench for sig_in_conditioner with a short debounce window.
module tb_sig_in_conditioner;
    import sig_cond_pkg::*;

    localparam int LAT = 2 + SIM_DEBOUNCE_CYCLES;

    typedef struct {
        int         at;
        logic [7:0] st;
        logic [7:0] r;
        logic [7:0] f;
    } exp_t;

    logic       sys_clock;
    logic       reset;
    logic [7:0] sig_raw;
    logic [7:0] sig_stable;
    logic [7:0] sig_rise;
    logic [7:0] sig_fall;
    logic       chg_any;

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       in_rst;
    logic [7:0] exp_st = 8'h00;
    exp_t       q[$];
    exp_t       e;
    int         c_last;

    sig_in_conditioner #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .RST_VAL         (8'h00)
    ) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .sig_raw    (sig_raw),
        .sig_stable (sig_stable),
        .sig_rise   (sig_rise),
        .sig_fall   (sig_fall),
        .chg_any    (chg_any)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    task automatic push_exp(input int at, input logic [7:0] st, input logic [7:0] r,
                            input logic [7:0] f);
        exp_t x;
        x.at = at;
        x.st = st;
        x.r  = r;
        x.f  = f;
        q.push_back(x);
    endtask

    // Drive a new pin value and predict the debounced outcome LAT edges later.
    task automatic step(input logic [7:0] v, input logic [7:0] st, input logic [7:0] r,
                        input logic [7:0] f);
        @(negedge sys_clock);
        sig_raw = v;
        push_exp(cyc + LAT, st, r, f);
        repeat (LAT + 3) @(negedge sys_clock);
    endtask

    always @(negedge sys_clock) begin
        if (in_rst) begin
            exp_st = 8'h00;
            chk("in_reset", {7'd0, sig_stable, sig_rise, sig_fall, chg_any}, 32'd0);
        end else if (q.size() > 0 && q[0].at == cyc) begin
            e = q.pop_front();
            exp_st = e.st;
            chk("event", {7'd0, sig_stable, sig_rise, sig_fall, chg_any},
                {7'd0, e.st, e.r, e.f, |(e.r | e.f)});
        end else begin
            chk("idle", {7'd0, sig_stable, sig_rise, sig_fall, chg_any},
                {7'd0, exp_st, 8'h00, 8'h00, 1'b0});
        end
    end

    initial begin
        in_rst  = 1'b1;
        reset   = 1'b0;
        sig_raw = 8'hFF;
        repeat (5) @(negedge sys_clock);

        // Release with all pins high: everything rises together.
        @(negedge sys_clock);
        reset  = 1'b1;
        in_rst = 1'b0;
        push_exp(cyc + LAT, 8'hFF, 8'hFF, 8'h00);
        repeat (LAT + 3) @(negedge sys_clock);

        step(8'h00, 8'h00, 8'h00, 8'hFF);
        step(8'h01, 8'h01, 8'h01, 8'h00);

        // Bit 3 glitch of 3 cycles: rejected.
        @(negedge sys_clock);
        sig_raw = 8'h09;
        repeat (3) @(negedge sys_clock);
        sig_raw = 8'h01;
        repeat (10) @(negedge sys_clock);

        // Bit 5 bounce 1,0,1,1,0,1 then held high.
        sig_raw[5] = 1'b1;
        @(negedge sys_clock); sig_raw[5] = 1'b0;
        @(negedge sys_clock); sig_raw[5] = 1'b1;
        @(negedge sys_clock);
        @(negedge sys_clock); sig_raw[5] = 1'b0;
        @(negedge sys_clock); sig_raw[5] = 1'b1;
        c_last = cyc;
        push_exp(c_last + LAT, 8'h21, 8'h20, 8'h00);
        repeat (LAT + 4) @(negedge sys_clock);

        step(8'h00, 8'h00, 8'h00, 8'h21);
        step(8'h81, 8'h81, 8'h81, 8'h00);
        step(8'h00, 8'h00, 8'h00, 8'h81);
        step(8'h81, 8'h81, 8'h81, 8'h00);

        // Bit 2 rises, reset lands with its counter at 2.
        @(negedge sys_clock);
        sig_raw = 8'h85;
        repeat (4) @(negedge sys_clock);
        #2;
        reset  = 1'b0;
        in_rst = 1'b1;
        #1;
        chk("async_rst", {7'd0, sig_stable, sig_rise, sig_fall, chg_any}, 32'd0);
        repeat (3) @(negedge sys_clock);
        @(negedge sys_clock);
        reset  = 1'b1;
        in_rst = 1'b0;
        push_exp(cyc + LAT, 8'h85, 8'h85, 8'h00);
        repeat (LAT + 6) @(negedge sys_clock);

        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
